// File: rtl/colparity_page_sequencer.sv
// Feeds the column-parity theta stage: takes a seed page, then sweeps
// bit index 0..24 over each page with its shifted column parity.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         begins a run (only honoured in IDLE)
//   page_in       25-bit page, lane (x,y) at bit 24-(5y+x)
//   page_valid    page_in valid; page_ready = block accepts it
//   index         bit index 0..24 during a sweep
//   index_valid   qualifies index, curr_parity and prev_page
//   curr_parity   shifted column parity of the current page
//   prev_page     previous page (seed page during page 0)
//   page_done     last sweep cycle of a page
//   done          one-cycle end-of-run pulse
//   busy          high outside IDLE
module colparity_page_sequencer #(
  parameter int NUM_PAGES = 64,
  parameter int WIDTH     = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] page_in,
  input  logic             page_valid,
  output logic             page_ready,
  output logic [4:0]       index,
  output logic             index_valid,
  output logic [WIDTH-1:0] curr_parity,
  output logic [WIDTH-1:0] prev_page,
  output logic             page_done,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(NUM_PAGES);
  localparam logic [CW-1:0] LAST = CW'(NUM_PAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WAIT,
    S_SWEEP,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [4:0]       col;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
    end
  end

  // Column parity from the held page; stable for the whole sweep.
  // Output bit k carries column (k+4) mod 5.
  always_comb begin
    col = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        col[x] = col[x] ^ cur_q[24-(5*y+x)];
      end
    end
    curr_parity = '0;
    for (int k = 0; k < 25; k++) begin
      curr_parity[k] = col[(k+4)%5];
    end
  end

  assign index     = idx_q;
  assign prev_page = prev_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    page_ready  = 1'b0;
    index_valid = 1'b0;
    page_done   = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_SEED;
          cnt_d   = '0;
        end
      end
      S_SEED: begin
        page_ready = 1'b1;
        if (page_valid) begin
          prev_d  = page_in;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        page_ready = 1'b1;
        if (page_valid) begin
          cur_d   = page_in;
          idx_d   = '0;
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        index_valid = 1'b1;
        if (idx_q == 5'd24) begin
          page_done = 1'b1;
          prev_d    = cur_q;
          cnt_d     = cnt_q + CW'(1);
          idx_d     = '0;
          state_d   = (cnt_q == LAST) ? S_FIN : S_WAIT;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_colparity_page_sequencer.sv
// Randomised bench for colparity_page_sequencer with a
// transaction-level reference model and directed literal checks.
module tb_colparity_page_sequencer;

  localparam int NP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        page_valid = 1'b0;
  logic [24:0] page_in = '0;
  logic        page_ready;
  logic [4:0]  index;
  logic        index_valid;
  logic [24:0] curr_parity;
  logic [24:0] prev_page;
  logic        page_done;
  logic        done;
  logic        busy;

  colparity_page_sequencer #(.NUM_PAGES(NP), .WIDTH(25)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .page_in(page_in),
    .page_valid(page_valid),
    .page_ready(page_ready),
    .index(index),
    .index_valid(index_valid),
    .curr_parity(curr_parity),
    .prev_page(prev_page),
    .page_done(page_done),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [24:0] par_ref(logic [24:0] p);
    logic [24:0] r;
    logic b;
    int x;
    r = '0;
    for (int k = 0; k < 25; k++) begin
      x = (k + 4) % 5;
      b = 1'b0;
      for (int y = 0; y < 5; y++) b = b ^ p[24-(5*y+x)];
      r[k] = b;
    end
    return r;
  endfunction

  // Reference model: a run is "seed, then NP pages of 25 sweep
  // cycles each, then one done cycle".
  bit          m_busy, m_seed, m_sw, m_fin;
  int          m_pos, m_pages;
  logic [24:0] m_cur, m_prev;

  initial begin
    m_busy = 0; m_seed = 0; m_sw = 0; m_fin = 0;
    m_pos = 0; m_pages = 0; m_cur = '0; m_prev = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_seed = 0; m_sw = 0; m_fin = 0;
        m_pos = 0; m_pages = 0; m_cur = '0; m_prev = '0;
      end else if (m_fin) begin
        m_fin = 0;
        m_busy = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_seed = 1; m_pages = 0;
        end
      end else if (m_sw) begin
        if (m_pos == 24) begin
          m_sw = 0; m_pos = 0; m_prev = m_cur; m_pages++;
          if (m_pages == NP) m_fin = 1;
        end else begin
          m_pos++;
        end
      end else if (page_valid) begin
        if (m_seed) begin
          m_prev = page_in;
          m_seed = 0;
        end else begin
          m_cur = page_in;
          m_sw = 1;
          m_pos = 0;
        end
      end
    end
  end

  int pd_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("busy", busy, m_busy);
      chk("page_ready", page_ready, m_busy && !m_sw && !m_fin);
      chk("index_valid", index_valid, m_sw);
      chk("index", index, m_pos);
      chk("page_done", page_done, m_sw && m_pos == 24);
      chk("done", done, m_fin);
      chk("prev_page", prev_page, m_prev);
      chk("curr_parity", curr_parity, par_ref(m_cur));
      if (rst) pd_cnt = 0;
      else if (page_done) pd_cnt++;
      if (done && !rst) begin
        chk("pages_per_run", pd_cnt, NP);
        pd_cnt = 0;
      end
    end
  end

  // Presents a page after gap idle cycles; returns at the negedge
  // following the accepting edge. Random start pulses while waiting.
  task automatic send(logic [24:0] data, int gap);
    bit ok;
    page_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      page_in = 25'($urandom);
      start = ($urandom_range(0, 7) == 0);
    end
    page_valid = 1'b1;
    page_in = data;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (page_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    if (ok) @(negedge clk);
    else chk("handshake_timeout", 0, 1);
    page_valid = 1'b0;
    page_in = 25'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    chk("done_seen", ok, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_index_valid", index_valid, 0);
    chk("rst_page_ready", page_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed run: seed 1, pages all-ones, single lane, zero.
    pulse_start();
    chk("seed_ready", page_ready, 1);
    chk("seed_busy", busy, 1);
    send(25'h0000001, 0);
    send(25'h1FFFFFF, 2);
    chk("p0_valid", index_valid, 1);
    chk("p0_index", index, 0);
    chk("p0_parity", curr_parity, 25'h1FFFFFF);
    chk("p0_prev_seed", prev_page, 25'h0000001);
    pulse_start();
    repeat (23) @(negedge clk);
    chk("p0_idx24", index, 24);
    chk("p0_page_done", page_done, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("gap_ready", page_ready, 1);
      chk("gap_no_sweep", index_valid, 0);
    end
    send(25'h1000000, 0);
    chk("p1_parity", curr_parity, 25'h0210842);
    chk("p1_prev", prev_page, 25'h1FFFFFF);
    repeat (24) @(negedge clk);
    chk("p1_page_done", page_done, 1);
    send(25'h0, 0);
    chk("p2_parity", curr_parity, 25'h0);
    chk("p2_prev", prev_page, 25'h1000000);
    repeat (24) @(negedge clk);
    chk("p2_page_done", page_done, 1);
    @(negedge clk);
    chk("fin_done", done, 1);
    start = 1'b1;
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    chk("idle_no_done", done, 0);
    @(negedge clk);
    start = 1'b0;
    chk("restart_ready", page_ready, 1);
    chk("restart_busy", busy, 1);

    // Reset in the middle of a sweep.
    send(25'($urandom), 1);
    send(25'($urandom), 0);
    repeat (12) @(negedge clk);
    chk("mid_index", index, 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_index", index, 0);
    chk("mr_valid", index_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_prev", prev_page, 0);
    chk("mr_parity", curr_parity, 0);
    chk("mr_done", done, 0);

    // Randomised runs.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_start();
      send(25'($urandom), $urandom_range(0, 3));
      for (int p = 0; p < NP; p++) begin
        send(25'($urandom), $urandom_range(0, 3));
      end
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
